// File: rtl/fp_serial_pkg.sv
// fp_serial_pkg: controller state encoding, word/exponent helpers and special-operand
// classes shared by the serial floating-point adder.
package fp_serial_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_ALIGN, ST_ADD, ST_NORM, ST_ROUND, ST_OUT, ST_DONE
  } state_e;

  // Operand classes that bypass the arithmetic path
  typedef enum logic [2:0] {
    SPC_NONE, SPC_INF_A, SPC_INF_B, SPC_PASS_A, SPC_PASS_B
  } spc_e;

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_shreg.sv
// fp_shreg: W-bit shift register, serial-in at the LSB, parallel load, MSB is the serial output.
module fp_shreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         load_en,
  input  logic         serial_in,
  input  logic [W-1:0] par_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         q <= '0;
    else if (load_en)  q <= par_in;
    else if (shift_en) q <= {q[W-2:0], serial_in};
  end

endmodule

// File: rtl/add_float_p.sv
// add_float_p: bit-serial floating-point add/subtract, operands and result MSB-first.
// Define ADD_FLOAT_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
//
// state   | meaning
// IDLE    | wait for go low
// LOAD_A  | shift in A, W cycles
// LOAD_B  | shift in B, W cycles; classify and unpack on the last bit
// ALIGN   | shift smaller significand right, one bit per cycle
// ADD     | magnitude add or subtract
// NORM    | carry right shift or left shifts until hidden bit set
// ROUND   | round-to-nearest-even (RNE build only)
// OUT     | shift result out, W cycles
// DONE    | one-cycle completion pulse
module add_float_p
  import fp_serial_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic sub,
  input  logic inpab,
  output logic shift,
  output logic out_c,
  output logic over,
  output logic under,
  output logic done
);

  localparam int W = word_w(EXP_W, MAN_W);
`ifdef ADD_FLOAT_RNE_EN
  localparam int GW = 3;
`else
  localparam int GW = 0;
`endif
  localparam int MW   = MAN_W + 1 + GW;
  localparam int EMAX = exp_max(EXP_W);
  localparam int CAP  = MAN_W + 3;
  localparam int CNTW = $clog2(W + 1);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d, align_n;
  logic [EXP_W-1:0] exp_q, exp_d, exp_a, exp_b, exp_dif;
  logic [MW-1:0]    man_x_q, man_x_d, man_y_q, man_y_d, man_a, man_b, y_sh;
  logic [MW:0]      acc_q, acc_d, acc_rsh;
  logic             sign_q, sign_d, eff_sub_q, eff_sub_d, sub_q, sub_d;
  logic             over_q, over_d, under_q, under_d;
  logic             sign_a, sign_b, a_big, a_shift, b_shift, res_load;
  logic [W-1:0]     a_q, b_q, b_word, res_word, spc_word, inf_word;
  logic             unused_b_msb;
  spc_e             spc;

  fp_shreg #(.W(W)) u_sh_a (
    .clk(clk), .reset(reset), .shift_en(a_shift), .load_en(res_load),
    .serial_in(inpab), .par_in(res_word), .q(a_q)
  );

  fp_shreg #(.W(W)) u_sh_b (
    .clk(clk), .reset(reset), .shift_en(b_shift), .load_en(1'b0),
    .serial_in(inpab), .par_in('0), .q(b_q)
  );

  // B is unpacked on the edge that samples its last bit, so that bit comes straight from inpab
  assign b_word       = {b_q[W-2:0], inpab};
  assign unused_b_msb = b_q[W-1];
  assign sign_a  = a_q[W-1];
  assign sign_b  = b_word[W-1] ^ sub_q;
  assign exp_a   = a_q[W-2 -: EXP_W];
  assign exp_b   = b_word[W-2 -: EXP_W];
  assign a_big   = a_q[W-2:0] >= b_word[W-2:0];
  assign man_a   = MW'({1'b1, a_q[MAN_W-1:0]}) << GW;
  assign man_b   = MW'({1'b1, b_word[MAN_W-1:0]}) << GW;
  assign exp_dif = a_big ? exp_a - exp_b : exp_b - exp_a;
  assign align_n = (32'(exp_dif) > 32'(CAP)) ? CNTW'(CAP) : CNTW'(exp_dif);
  assign inf_word = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  always_comb begin
    spc      = SPC_NONE;
    spc_word = '0;
    if (exp_a == EXP_W'(EMAX)) begin
      spc = SPC_INF_A;  spc_word = {sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_b == EXP_W'(EMAX)) begin
      spc = SPC_INF_B;  spc_word = {sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_a == '0) begin
      spc = SPC_PASS_B; spc_word = {sign_b, b_word[W-2:0]};
    end else if (exp_b == '0) begin
      spc = SPC_PASS_A; spc_word = a_q;
    end
  end

  always_comb begin
    y_sh    = man_y_q >> 1;
    acc_rsh = acc_q >> 1;
`ifdef ADD_FLOAT_RNE_EN
    y_sh[0]    = man_y_q[1] | man_y_q[0];
    acc_rsh[0] = acc_q[1] | acc_q[0];
`endif
  end

`ifdef ADD_FLOAT_RNE_EN
  logic             rnd_up;
  logic [MAN_W+1:0] rnd_sum;
  assign rnd_up  = acc_q[2] & (acc_q[3] | acc_q[1] | acc_q[0]);
  assign rnd_sum = {1'b0, acc_q[MW-1:GW]} + {{(MAN_W+1){1'b0}}, rnd_up};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    man_x_d   = man_x_q;
    man_y_d   = man_y_q;
    acc_d     = acc_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    sub_d     = sub_q;
    over_d    = over_q;
    under_d   = under_q;
    a_shift   = 1'b0;
    b_shift   = 1'b0;
    res_load  = 1'b0;
    res_word  = '0;
    case (state_q)
      ST_IDLE: if (!go) begin
        state_d = ST_LOAD_A; cnt_d = CNTW'(W - 1); sub_d = sub;
        over_d  = 1'b0;      under_d = 1'b0;
      end
      ST_LOAD_A: begin
        a_shift = 1'b1;
        if (cnt_q == '0) begin state_d = ST_LOAD_B; cnt_d = CNTW'(W - 1); end
        else cnt_d = cnt_q - 1'b1;
      end
      ST_LOAD_B: begin
        b_shift = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (spc != SPC_NONE) begin
          state_d = ST_OUT; cnt_d = CNTW'(W - 1); res_load = 1'b1; res_word = spc_word;
          over_d  = (spc == SPC_INF_A) || (spc == SPC_INF_B);
        end else begin
          state_d   = ST_ALIGN;
          cnt_d     = align_n;
          exp_d     = a_big ? exp_a : exp_b;
          man_x_d   = a_big ? man_a : man_b;
          man_y_d   = a_big ? man_b : man_a;
          sign_d    = a_big ? sign_a : sign_b;
          eff_sub_d = sign_a ^ sign_b;
        end
      end
      ST_ALIGN: begin
        if (cnt_q == '0) state_d = ST_ADD;
        else begin man_y_d = y_sh; cnt_d = cnt_q - 1'b1; end
      end
      ST_ADD: begin
        acc_d   = eff_sub_q ? {1'b0, man_x_q} - {1'b0, man_y_q} : {1'b0, man_x_q} + {1'b0, man_y_q};
        state_d = ST_NORM;
      end
      ST_NORM: begin
        cnt_d = CNTW'(W - 1);
        if (acc_q == '0) begin
          state_d = ST_OUT; res_load = 1'b1;
        end else if (acc_q[MW]) begin
          if (exp_q == EXP_W'(EMAX - 1)) begin
            state_d = ST_OUT; res_load = 1'b1; res_word = inf_word; over_d = 1'b1;
          end else begin
            acc_d = acc_rsh; exp_d = exp_q + 1'b1;
          end
        end else if (acc_q[MW-1]) begin
`ifdef ADD_FLOAT_RNE_EN
          state_d = ST_ROUND;
`else
          state_d = ST_OUT; res_load = 1'b1; res_word = {sign_q, exp_q, acc_q[GW +: MAN_W]};
`endif
        end else if (exp_q == EXP_W'(1)) begin
          state_d = ST_OUT; res_load = 1'b1; res_word = {sign_q, {(W-1){1'b0}}}; under_d = 1'b1;
        end else begin
          acc_d = acc_q << 1; exp_d = exp_q - 1'b1;
        end
      end
`ifdef ADD_FLOAT_RNE_EN
      ST_ROUND: begin
        state_d = ST_OUT; cnt_d = CNTW'(W - 1); res_load = 1'b1;
        if (rnd_sum[MAN_W+1]) begin
          if (exp_q == EXP_W'(EMAX - 1)) begin res_word = inf_word; over_d = 1'b1; end
          else res_word = {sign_q, exp_q + 1'b1, rnd_sum[MAN_W:1]};
        end else res_word = {sign_q, exp_q, rnd_sum[MAN_W-1:0]};
      end
`endif
      ST_OUT: begin
        a_shift = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
        else cnt_d = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE; cnt_q <= '0;     exp_q <= '0;     man_x_q <= '0; man_y_q <= '0;
      acc_q   <= '0;      sign_q <= 1'b0;  eff_sub_q <= 1'b0; sub_q <= 1'b0;
      over_q  <= 1'b0;    under_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;   exp_q <= exp_d;  man_x_q <= man_x_d; man_y_q <= man_y_d;
      acc_q   <= acc_d;   sign_q <= sign_d; eff_sub_q <= eff_sub_d; sub_q <= sub_d;
      over_q  <= over_d;  under_q <= under_d;
    end
  end

  assign shift = (state_q == ST_OUT);
  assign out_c = shift & a_q[W-1];
  assign done  = (state_q == ST_DONE);
  assign over  = over_q;
  assign under = under_q;

endmodule

// File: tb/tb_add_float_p.sv
// tb_add_float_p: directed scoreboard bench for the serial float adder, 32-bit and 16-bit instances.
module tb_add_float_p;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic go32 = 1'b1, go16 = 1'b1, sub = 1'b0, inpab = 1'b0;
  logic shift32, out_c32, over32, under32, done32;
  logic shift16, out_c16, over16, under16, done16;
  bit   use16 = 1'b0;
  logic shift_s, out_c_s, over_s, under_s, done_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] word;
    logic        ov;
    logic        un;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  add_float_p dut32 (
    .clk(clk), .reset(reset), .go(go32), .sub(sub), .inpab(inpab),
    .shift(shift32), .out_c(out_c32), .over(over32), .under(under32), .done(done32)
  );

  add_float_p #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .reset(reset), .go(go16), .sub(sub), .inpab(inpab),
    .shift(shift16), .out_c(out_c16), .over(over16), .under(under16), .done(done16)
  );

  assign shift_s = use16 ? shift16 : shift32;
  assign out_c_s = use16 ? out_c16 : out_c32;
  assign over_s  = use16 ? over16  : over32;
  assign under_s = use16 ? under16 : under32;
  assign done_s  = use16 ? done16  : done32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input bit s16, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ew, input logic eov, input logic eun, input string tag);
    exp_t        e;
    int          w, cyc, nshift;
    logic [31:0] got;
    w = s16 ? 16 : 32;
    use16 = s16;
    sb.push_back('{word: ew, ov: eov, un: eun});
    @(negedge clk);
    sub = s;
    if (s16) go16 = 1'b0; else go32 = 1'b0;
    for (int i = 0; i < 2 * w; i++) begin
      @(negedge clk);
      go16 = 1'b1; go32 = 1'b1;
      inpab = (i < w) ? a[w-1-i] : b[2*w-1-i];
    end
    cyc = 0;
    do begin
      @(negedge clk);
      inpab = 1'b0;
      cyc++;
    end while (shift_s !== 1'b1 && cyc < 120);
    e = sb.pop_front();
    chk({tag, " shift start"}, {31'b0, shift_s}, 32'd1);
    if (shift_s !== 1'b1) return;
    chk({tag, " over"},  {31'b0, over_s},  {31'b0, e.ov});
    chk({tag, " under"}, {31'b0, under_s}, {31'b0, e.un});
    got = '0;
    nshift = 0;
    for (int i = 0; i < w; i++) begin
      if (shift_s === 1'b1) nshift++;
      got = {got[30:0], out_c_s};
      @(negedge clk);
    end
    chk({tag, " result"}, got, e.word);
    chk({tag, " shift count"}, 32'(nshift), 32'(w));
    chk({tag, " done pulse"}, {30'b0, done_s, shift_s}, 32'b10);
    @(negedge clk);
    chk({tag, " done clear"}, {31'b0, done_s}, 32'd0);
  endtask

  initial begin
    logic [31:0] a1, b1;
    int          nbusy;
    repeat (3) @(negedge clk);
    chk("reset outputs 32", {27'b0, shift32, out_c32, over32, under32, done32}, 32'd0);
    chk("reset outputs 16", {27'b0, shift16, out_c16, over16, under16, done16}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(0, 32'h3F000000, 32'h3EE00000, 1'b0, 32'h3F700000, 1'b0, 1'b0, "add half");
    run_op(0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, "cancel");
    run_op(0, 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, "sub 2-1");
    run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, "overflow");
    repeat (4) @(negedge clk);
    chk("over held", {31'b0, over32}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset clears over", {27'b0, shift32, out_c32, over32, under32, done32}, 32'd0);
    reset = 1'b0;
    run_op(0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, "underflow");
    run_op(0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, "tie even");
`ifdef ADD_FLOAT_RNE_EN
    run_op(0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, "tie odd");
`else
    run_op(0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 1'b0, 1'b0, "tie odd");
`endif
    run_op(0, 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0, "signs cancel");
    run_op(0, 32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 1'b0, 1'b0, "zero a");
    run_op(0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7F800000, 1'b1, 1'b0, "inf a wins");
    run_op(0, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b1, 1'b0, "inf b neg");

    // abort during LOAD_B: no result may appear afterwards
    use16 = 1'b0;
    a1 = 32'h3F000000;
    b1 = 32'h3EE00000;
    @(negedge clk);
    sub = 1'b0; go32 = 1'b0;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      go32 = 1'b1;
      inpab = (i < 32) ? a1[31-i] : b1[63-i];
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset outputs", {27'b0, shift32, out_c32, over32, under32, done32}, 32'd0);
    reset = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      inpab = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (shift32 === 1'b1 || done32 === 1'b1) nbusy++;
    end
    chk("aborted op silent", 32'(nbusy), 32'd0);
    inpab = 1'b0;
    run_op(0, 32'h3F000000, 32'h3EE00000, 1'b0, 32'h3F700000, 1'b0, 1'b0, "after reset");

    run_op(1, 32'h00003800, 32'h00003700, 1'b0, 32'h00003B80, 1'b0, 1'b0, "half add16");
    run_op(1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 1'b0, 1'b0, "carry16");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
